// File: rtl/dcache_l2_pkg.sv
// Shared constants, FSM state encoding and address helpers for the
// data-cache to L2 burst bridge.
package dcache_l2_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int ADDRESS_WIDTH = 32;
    localparam int BLOCK_SIZE    = 32;
    localparam int BEAT_WIDTH    = 32;
    localparam int LW            = DATA_WIDTH * BLOCK_SIZE;
    localparam int NBEATS        = LW / BEAT_WIDTH;
    localparam int OFFSET_WIDTH  = $clog2(LW / 8);
    localparam int LA            = ADDRESS_WIDTH - OFFSET_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        WB_AW,
        WB_W,
        WB_B,
        RD_AR,
        RD_R,
        RD_DONE
    } state_t;

    function automatic logic [ADDRESS_WIDTH-1:0] line_to_byte_addr(
        input logic [LA-1:0] line
    );
        return {line, {OFFSET_WIDTH{1'b0}}};
    endfunction

endpackage

// File: rtl/line_beat_buffer.sv
// Refill line register with a beat-indexed write port, plus the
// beat-indexed read mux used to serialise write-back lines.
module line_beat_buffer #(
    parameter int LW = 1024,
    parameter int BW = 32,
    parameter int IW = 5
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [BW-1:0] wr_beat,
    output logic [LW-1:0] line,
    input  logic [LW-1:0] src_line,
    input  logic [IW-1:0] rd_idx,
    output logic [BW-1:0] rd_beat
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            line <= '0;
        end else if (wr_en) begin
            line[int'(wr_idx)*BW +: BW] <= wr_beat;
        end
    end

    assign rd_beat = src_line[int'(rd_idx)*BW +: BW];

endmodule

// File: rtl/dcache_l2_bridge.sv
// Bridge between the data cache miss/write-back port and a burst memory
// port; write-backs always drain before refills.
module dcache_l2_bridge
    import dcache_l2_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int BLOCK_SIZE    = 32,
    parameter int BEAT_WIDTH    = 32,
    localparam int LINE_W       = DATA_WIDTH * BLOCK_SIZE,
    localparam int N_BEATS      = LINE_W / BEAT_WIDTH,
    localparam int OFF_W        = $clog2(LINE_W / 8),
    localparam int LINE_A_W     = ADDRESS_WIDTH - OFF_W
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     ADDR_TO_L2_VALID,
    input  logic [LINE_A_W-1:0]      ADDR_TO_L2,
    output logic [LINE_W-1:0]        DATA_FROM_L2,
    output logic                     DATA_FROM_L2_VALID,
    input  logic                     DATA_TO_L2_VALID,
    input  logic [LINE_A_W-1:0]      WADDR_TO_L2,
    input  logic [LINE_W-1:0]        DATA_TO_L2,
    output logic                     WB_DONE,
    output logic                     BUSY,
    output logic [ADDRESS_WIDTH-1:0] MEM_RADDR,
    output logic                     MEM_RADDR_VALID,
    input  logic                     MEM_RADDR_READY,
    input  logic [BEAT_WIDTH-1:0]    MEM_RDATA,
    input  logic                     MEM_RDATA_VALID,
    input  logic                     MEM_RLAST,
    output logic [ADDRESS_WIDTH-1:0] MEM_WADDR,
    output logic                     MEM_WADDR_VALID,
    input  logic                     MEM_WADDR_READY,
    output logic [BEAT_WIDTH-1:0]    MEM_WDATA,
    output logic                     MEM_WDATA_VALID,
    input  logic                     MEM_WDATA_READY,
    output logic                     MEM_WLAST,
    input  logic                     MEM_WRESP_VALID,
    output logic                     ERR
);

    localparam int CNT_W = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BEATS - 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                rd_full;
    logic                wb_full;
    logic [LINE_A_W-1:0] rd_addr;
    logic [LINE_A_W-1:0] wb_addr;
    logic [LINE_W-1:0]   wb_line;
    logic                rd_free;
    logic                wb_free;
    logic                rd_load;
    logic                wb_load;
    logic                beat_wr;

    assign wb_free = (state == WB_B) && MEM_WRESP_VALID;
    assign rd_free = (state == RD_DONE);
    assign wb_load = DATA_TO_L2_VALID && (!wb_full || wb_free);
    assign rd_load = ADDR_TO_L2_VALID && (!rd_full || rd_free);
    assign beat_wr = (state == RD_R) && MEM_RDATA_VALID;

    assign MEM_WLAST = MEM_WDATA_VALID && (cnt == LAST);
    assign BUSY      = rd_full || wb_full || (state != IDLE);

    // A slot stays full while it is being serviced and may be
    // refilled on the very edge that frees it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wb_full <= 1'b0;
            wb_addr <= '0;
            wb_line <= '0;
            rd_full <= 1'b0;
            rd_addr <= '0;
        end else begin
            if (wb_load) begin
                wb_full <= 1'b1;
                wb_addr <= WADDR_TO_L2;
                wb_line <= DATA_TO_L2;
            end else if (wb_free) begin
                wb_full <= 1'b0;
            end
            if (rd_load) begin
                rd_full <= 1'b1;
                rd_addr <= ADDR_TO_L2;
            end else if (rd_free) begin
                rd_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state              <= IDLE;
            cnt                <= '0;
            MEM_RADDR          <= '0;
            MEM_RADDR_VALID    <= 1'b0;
            MEM_WADDR          <= '0;
            MEM_WADDR_VALID    <= 1'b0;
            MEM_WDATA_VALID    <= 1'b0;
            WB_DONE            <= 1'b0;
            DATA_FROM_L2_VALID <= 1'b0;
            ERR                <= 1'b0;
        end else begin
            WB_DONE            <= 1'b0;
            DATA_FROM_L2_VALID <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (wb_full || DATA_TO_L2_VALID) begin
                        state           <= WB_AW;
                        MEM_WADDR_VALID <= 1'b1;
                        MEM_WADDR       <= {(wb_full ? wb_addr : WADDR_TO_L2),
                                            {OFF_W{1'b0}}};
                    end else if (rd_full || ADDR_TO_L2_VALID) begin
                        state           <= RD_AR;
                        MEM_RADDR_VALID <= 1'b1;
                        MEM_RADDR       <= {(rd_full ? rd_addr : ADDR_TO_L2),
                                            {OFF_W{1'b0}}};
                    end
                end
                WB_AW: begin
                    if (MEM_WADDR_READY) begin
                        MEM_WADDR_VALID <= 1'b0;
                        MEM_WDATA_VALID <= 1'b1;
                        state           <= WB_W;
                    end
                end
                WB_W: begin
                    if (MEM_WDATA_READY) begin
                        if (cnt == LAST) begin
                            cnt             <= '0;
                            MEM_WDATA_VALID <= 1'b0;
                            state           <= WB_B;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                WB_B: begin
                    if (MEM_WRESP_VALID) begin
                        WB_DONE <= 1'b1;
                        state   <= IDLE;
                    end
                end
                RD_AR: begin
                    if (MEM_RADDR_READY) begin
                        MEM_RADDR_VALID <= 1'b0;
                        state           <= RD_R;
                    end
                end
                RD_R: begin
                    // Beat count decides completion; RLAST only feeds ERR.
                    if (MEM_RDATA_VALID) begin
                        if (MEM_RLAST != (cnt == LAST)) begin
                            ERR <= 1'b1;
                        end
                        if (cnt == LAST) begin
                            cnt                <= '0;
                            DATA_FROM_L2_VALID <= 1'b1;
                            state              <= RD_DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RD_DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    line_beat_buffer #(
        .LW (LINE_W),
        .BW (BEAT_WIDTH),
        .IW (CNT_W)
    ) u_buf (
        .CLK      (CLK),
        .RST      (RST),
        .wr_en    (beat_wr),
        .wr_idx   (cnt),
        .wr_beat  (MEM_RDATA),
        .line     (DATA_FROM_L2),
        .src_line (wb_line),
        .rd_idx   (cnt),
        .rd_beat  (MEM_WDATA)
    );

endmodule

// File: tb/tb_dcache_l2_bridge.sv
// Directed scoreboard bench for dcache_l2_bridge.
module tb_dcache_l2_bridge;

    logic          CLK;
    logic          RST;
    logic          ADDR_TO_L2_VALID;
    logic [24:0]   ADDR_TO_L2;
    logic [1023:0] DATA_FROM_L2;
    logic          DATA_FROM_L2_VALID;
    logic          DATA_TO_L2_VALID;
    logic [24:0]   WADDR_TO_L2;
    logic [1023:0] DATA_TO_L2;
    logic          WB_DONE;
    logic          BUSY;
    logic [31:0]   MEM_RADDR;
    logic          MEM_RADDR_VALID;
    logic          MEM_RADDR_READY;
    logic [31:0]   MEM_RDATA;
    logic          MEM_RDATA_VALID;
    logic          MEM_RLAST;
    logic [31:0]   MEM_WADDR;
    logic          MEM_WADDR_VALID;
    logic          MEM_WADDR_READY;
    logic [31:0]   MEM_WDATA;
    logic          MEM_WDATA_VALID;
    logic          MEM_WDATA_READY;
    logic          MEM_WLAST;
    logic          MEM_WRESP_VALID;
    logic          ERR;

    int checks = 0;
    int errors = 0;

    logic [1023:0] rq[$];
    logic [31:0]   wq[$];

    dcache_l2_bridge dut (
        .CLK                (CLK),
        .RST                (RST),
        .ADDR_TO_L2_VALID   (ADDR_TO_L2_VALID),
        .ADDR_TO_L2         (ADDR_TO_L2),
        .DATA_FROM_L2       (DATA_FROM_L2),
        .DATA_FROM_L2_VALID (DATA_FROM_L2_VALID),
        .DATA_TO_L2_VALID   (DATA_TO_L2_VALID),
        .WADDR_TO_L2        (WADDR_TO_L2),
        .DATA_TO_L2         (DATA_TO_L2),
        .WB_DONE            (WB_DONE),
        .BUSY               (BUSY),
        .MEM_RADDR          (MEM_RADDR),
        .MEM_RADDR_VALID    (MEM_RADDR_VALID),
        .MEM_RADDR_READY    (MEM_RADDR_READY),
        .MEM_RDATA          (MEM_RDATA),
        .MEM_RDATA_VALID    (MEM_RDATA_VALID),
        .MEM_RLAST          (MEM_RLAST),
        .MEM_WADDR          (MEM_WADDR),
        .MEM_WADDR_VALID    (MEM_WADDR_VALID),
        .MEM_WADDR_READY    (MEM_WADDR_READY),
        .MEM_WDATA          (MEM_WDATA),
        .MEM_WDATA_VALID    (MEM_WDATA_VALID),
        .MEM_WDATA_READY    (MEM_WDATA_READY),
        .MEM_WLAST          (MEM_WLAST),
        .MEM_WRESP_VALID    (MEM_WRESP_VALID),
        .ERR                (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [1023:0] make_line(input logic [31:0] base);
        logic [1023:0] l;
        for (int i = 0; i < 32; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_line(input string tag, input logic [1023:0] obs,
                            input logic [1023:0] exp);
        int bad;
        bad = 0;
        for (int i = 31; i >= 0; i--)
            if (obs[i*32 +: 32] !== exp[i*32 +: 32]) bad = i;
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s beat %0d observed=%h expected=%h", tag, bad,
                   obs[bad*32 +: 32], exp[bad*32 +: 32]);
        end
    endtask

    task automatic req_refill(input logic [24:0] la, input logic [31:0] base);
        ADDR_TO_L2_VALID = 1'b1;
        ADDR_TO_L2       = la;
        rq.push_back(make_line(base));
        @(negedge CLK);
        ADDR_TO_L2_VALID = 1'b0;
    endtask

    task automatic req_wb(input logic [24:0] wa, input logic [1023:0] line);
        DATA_TO_L2_VALID = 1'b1;
        WADDR_TO_L2      = wa;
        DATA_TO_L2       = line;
        for (int i = 0; i < 32; i++) wq.push_back(line[i*32 +: 32]);
        @(negedge CLK);
        DATA_TO_L2_VALID = 1'b0;
    endtask

    task automatic serve_refill(input string tag, input logic [31:0] exp_addr,
                                input logic [31:0] base, input int gap,
                                input int early, input bit nolast,
                                input int abort, input bit exp_err);
        int t;
        logic [1023:0] exp;
        t = 0;
        while (MEM_RADDR_VALID !== 1'b1 && t < 200) begin
            @(negedge CLK);
            t++;
        end
        chk({tag, "_raddr_valid"}, MEM_RADDR_VALID, 1);
        chk({tag, "_raddr"}, MEM_RADDR, exp_addr);
        MEM_RADDR_READY = 1'b1;
        @(negedge CLK);
        MEM_RADDR_READY = 1'b0;
        chk({tag, "_raddr_drop"}, MEM_RADDR_VALID, 0);
        for (int i = 0; i < 32; i++) begin
            repeat (gap) begin
                MEM_RDATA_VALID = 1'b0;
                @(negedge CLK);
            end
            MEM_RDATA_VALID = 1'b1;
            MEM_RDATA       = base + 32'(i);
            MEM_RLAST       = ((i == 31) && !nolast) || (i == early);
            if (i == abort) begin
                RST = 1'b1;
                @(negedge CLK);
                MEM_RDATA_VALID = 1'b0;
                MEM_RLAST       = 1'b0;
                return;
            end
            if (i == 31) chk({tag, "_no_early_pulse"}, DATA_FROM_L2_VALID, 0);
            @(negedge CLK);
        end
        MEM_RDATA_VALID = 1'b0;
        MEM_RLAST       = 1'b0;
        chk({tag, "_pulse"}, DATA_FROM_L2_VALID, 1);
        exp = (rq.size() != 0) ? rq.pop_front() : '0;
        chk_line({tag, "_line"}, DATA_FROM_L2, exp);
        @(negedge CLK);
        chk({tag, "_pulse_end"}, DATA_FROM_L2_VALID, 0);
        chk({tag, "_err"}, ERR, exp_err);
    endtask

    task automatic serve_wb(input string tag, input logic [31:0] exp_addr,
                            input bit bp);
        int t;
        bit rseen;
        t     = 0;
        rseen = 1'b0;
        while (MEM_WADDR_VALID !== 1'b1 && t < 200) begin
            rseen |= MEM_RADDR_VALID;
            @(negedge CLK);
            t++;
        end
        chk({tag, "_waddr_valid"}, MEM_WADDR_VALID, 1);
        chk({tag, "_waddr"}, MEM_WADDR, exp_addr);
        MEM_WADDR_READY = 1'b1;
        @(negedge CLK);
        MEM_WADDR_READY = 1'b0;
        t = 0;
        while (wq.size() != 0 && t < 400) begin
            MEM_WDATA_READY = bp ? (t % 2 == 0) : 1'b1;
            rseen |= MEM_RADDR_VALID;
            if (MEM_WDATA_VALID === 1'b1 && MEM_WDATA_READY) begin
                chk({tag, "_wlast"}, MEM_WLAST, wq.size() == 1);
                chk({tag, "_wdata"}, MEM_WDATA, wq.pop_front());
            end
            @(negedge CLK);
            t++;
        end
        MEM_WDATA_READY = 1'b0;
        chk({tag, "_beats_left"}, wq.size(), 0);
        chk({tag, "_wvalid_drop"}, MEM_WDATA_VALID, 0);
        @(negedge CLK);
        chk({tag, "_no_early_done"}, WB_DONE, 0);
        MEM_WRESP_VALID = 1'b1;
        @(negedge CLK);
        MEM_WRESP_VALID = 1'b0;
        rseen |= MEM_RADDR_VALID;
        chk({tag, "_done"}, WB_DONE, 1);
        @(negedge CLK);
        chk({tag, "_done_end"}, WB_DONE, 0);
        chk({tag, "_no_raddr_before_done"}, rseen, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {DATA_FROM_L2_VALID, WB_DONE, BUSY, MEM_RADDR_VALID,
                            MEM_WADDR_VALID, MEM_WDATA_VALID, MEM_WLAST, ERR}, 0);
        chk({tag, "_raddr"}, MEM_RADDR, 0);
        chk({tag, "_waddr"}, MEM_WADDR, 0);
        chk({tag, "_wdata"}, MEM_WDATA, 0);
        chk_line({tag, "_line"}, DATA_FROM_L2, '0);
    endtask

    initial begin
        logic [1023:0] l;
        RST              = 1'b1;
        ADDR_TO_L2_VALID = 1'b0;
        ADDR_TO_L2       = '0;
        DATA_TO_L2_VALID = 1'b0;
        WADDR_TO_L2      = '0;
        DATA_TO_L2       = '0;
        MEM_RADDR_READY  = 1'b0;
        MEM_RDATA        = '0;
        MEM_RDATA_VALID  = 1'b0;
        MEM_RLAST        = 1'b0;
        MEM_WADDR_READY  = 1'b0;
        MEM_WDATA_READY  = 1'b0;
        MEM_WRESP_VALID  = 1'b0;
        repeat (3) @(negedge CLK);
        chk_all_zero("reset");
        RST = 1'b0;
        @(negedge CLK);

        req_refill(25'h000040, 32'h1000);
        chk("t1_raddr_valid_n1", MEM_RADDR_VALID, 1);
        chk("t1_busy", BUSY, 1);
        serve_refill("t1", 32'h00002000, 32'h1000, 0, -1, 0, -1, 0);
        chk("t1_lo", DATA_FROM_L2[31:0], 32'h1000);
        chk("t1_hi", DATA_FROM_L2[1023:992], 32'h101F);
        chk("t1_idle", BUSY, 0);

        for (int i = 0; i < 32; i++) l[i*32 +: 32] = 32'(i);
        req_wb(25'h1, l);
        chk("t2_waddr_valid_n1", MEM_WADDR_VALID, 1);
        serve_wb("t2", 32'h00000080, 0);
        chk_line("t2_hold", DATA_FROM_L2, make_line(32'h1000));
        chk("t2_idle", BUSY, 0);

        for (int i = 0; i < 32; i++) l[i*32 +: 32] = 32'hA000 + 32'(i);
        ADDR_TO_L2_VALID = 1'b1;
        ADDR_TO_L2       = 25'h3;
        rq.push_back(make_line(32'h2000));
        req_wb(25'h2, l);
        ADDR_TO_L2_VALID = 1'b0;
        chk("t3_raddr_held", MEM_RADDR_VALID, 0);
        serve_wb("t3", 32'h00000100, 0);
        serve_refill("t3", 32'h00000180, 32'h2000, 0, -1, 0, -1, 0);

        for (int i = 0; i < 32; i++) l[i*32 +: 32] = 32'hDEAD0000 ^ 32'(i * 7);
        req_wb(25'h155, l);
        serve_wb("t4", 32'h0000AA80, 1);
        req_refill(25'h7F, 32'h50000000);
        serve_refill("t4", 32'h00003F80, 32'h50000000, 3, -1, 0, -1, 0);

        req_refill(25'h10, 32'h6000);
        serve_refill("t5_early", 32'h00000800, 32'h6000, 0, 10, 0, -1, 1);
        req_refill(25'h11, 32'h7000);
        serve_refill("t5_sticky", 32'h00000880, 32'h7000, 0, -1, 0, -1, 1);
        RST = 1'b1;
        @(negedge CLK);
        chk("t5_err_cleared", ERR, 0);
        RST = 1'b0;
        @(negedge CLK);

        req_refill(25'h20, 32'h8000);
        serve_refill("t6_nolast", 32'h00001000, 32'h8000, 0, -1, 1, -1, 1);

        req_refill(25'h30, 32'h9000);
        serve_refill("t7", 32'h00001800, 32'h9000, 0, -1, 0, 15, 0);
        chk_all_zero("t7_midrst");
        rq.delete();
        RST = 1'b0;
        @(negedge CLK);

        req_refill(25'h1FFFFFF, 32'hC000);
        serve_refill("t8", 32'hFFFFFF80, 32'hC000, 1, -1, 0, -1, 0);
        chk("t8_idle", BUSY, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
